// File: rtl/ysyx_25030093_csr_unit.sv
// Machine-mode CSR file: mstatus/mtvec/mscratch/mepc/mcause, trap entry, mret and fetch redirect.
// Define YSYX_25030093_CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters.
module ysyx_25030093_csr_unit #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  MTVEC_RST   = '0,
    parameter logic [XLEN-1:0]  MSTATUS_RST = 'h1800
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    input  logic            retire,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mie_o
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MINSTRETH= 12'hB82;

    logic            mie, mpie;
    logic [XLEN-1:0] mtvec, mscratch, mepc, mcause;
    logic [XLEN-1:0] mstatus_val, nv;
    logic            hit, wr_en;

`ifdef YSYX_25030093_CSR_COUNTERS_EN
    logic [2*XLEN-1:0] mcycle, minstret;
`endif

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = mpie;
        mstatus_val[3]     = mie;
    end

    always_comb begin
        csr_rdata = '0;
        hit       = 1'b1;
        case (csr_addr)
            A_MSTATUS:   csr_rdata = mstatus_val;
            A_MTVEC:     csr_rdata = mtvec;
            A_MSCRATCH:  csr_rdata = mscratch;
            A_MEPC:      csr_rdata = mepc;
            A_MCAUSE:    csr_rdata = mcause;
`ifdef YSYX_25030093_CSR_COUNTERS_EN
            A_MCYCLE:    csr_rdata = mcycle[XLEN-1:0];
            A_MCYCLEH:   csr_rdata = mcycle[2*XLEN-1:XLEN];
            A_MINSTRET:  csr_rdata = minstret[XLEN-1:0];
            A_MINSTRETH: csr_rdata = minstret[2*XLEN-1:XLEN];
`endif
            default:     hit = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b01:   nv = csr_wdata;
            2'b10:   nv = csr_rdata | csr_wdata;
            2'b11:   nv = csr_rdata & ~csr_wdata;
            default: nv = csr_rdata;
        endcase
    end

    // RS/RC with a zero mask are pure reads; a trap swallows any write.
    assign wr_en = (csr_op != 2'b00) && hit && !trap_valid &&
                   !(csr_op[1] && (csr_wdata == '0));
    assign csr_illegal    = (csr_op != 2'b00) && !hit;
    assign redirect_valid = trap_valid | mret_valid;
    assign redirect_pc    = trap_valid ? {mtvec[XLEN-1:2], 2'b00} :
                            mret_valid ? mepc : '0;
    assign mie_o          = mie;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie      <= MSTATUS_RST[3];
            mpie     <= MSTATUS_RST[7];
            mtvec    <= {MTVEC_RST[XLEN-1:2], 2'b00};
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else if (trap_valid) begin
            mepc   <= {trap_pc[XLEN-1:2], 2'b00};
            mcause <= trap_cause;
            mpie   <= mie;
            mie    <= 1'b0;
        end else begin
            // mret owns mstatus; writes to the other CSRs still land alongside it.
            if (mret_valid) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (wr_en && csr_addr == A_MSTATUS) begin
                mie  <= nv[3];
                mpie <= nv[7];
            end
            if (wr_en) begin
                case (csr_addr)
                    A_MTVEC:    mtvec    <= {nv[XLEN-1:2], 2'b00};
                    A_MSCRATCH: mscratch <= nv;
                    A_MEPC:     mepc     <= {nv[XLEN-1:2], 2'b00};
                    A_MCAUSE:   mcause   <= nv;
                    default:    ;
                endcase
            end
        end
    end

`ifdef YSYX_25030093_CSR_COUNTERS_EN
    logic unused_pc_bits;
    assign unused_pc_bits = ^trap_pc[1:0];

    // A write to one half replaces it; the other half holds and the count skips this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr_en && csr_addr == A_MCYCLE)        mcycle[XLEN-1:0]        <= nv;
            else if (wr_en && csr_addr == A_MCYCLEH)  mcycle[2*XLEN-1:XLEN]   <= nv;
            else                                      mcycle                  <= mcycle + 1'b1;

            if (wr_en && csr_addr == A_MINSTRET)      minstret[XLEN-1:0]      <= nv;
            else if (wr_en && csr_addr == A_MINSTRETH) minstret[2*XLEN-1:XLEN] <= nv;
            else if (retire && !trap_valid)           minstret                <= minstret + 1'b1;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{retire, trap_pc[1:0]};
`endif

endmodule

// File: tb/tb_ysyx_25030093_csr_unit.sv
// Directed bench for ysyx_25030093_csr_unit: reset, CSR ops, trap/mret sequencing, counters.
module tb_ysyx_25030093_csr_unit;
    logic        clk, rst;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata, csr_rdata, trap_cause, trap_pc, redirect_pc;
    logic        csr_illegal, trap_valid, mret_valid, retire, redirect_valid, mie_o;
    int          n_chk, n_err;

    ysyx_25030093_csr_unit dut (
        .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .trap_valid(trap_valid),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .mret_valid(mret_valid), .retire(retire),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mie_o(mie_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        csr_addr = 12'h000; csr_op = 2'b00; csr_wdata = '0;
        trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; mret_valid = 1'b0; retire = 1'b0;
    endtask

    // drive a CSR op for the coming edge and let combinational outputs settle
    task automatic drive(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        csr_addr = a; csr_op = op; csr_wdata = wd; #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
        idle(); #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        drive(a, 2'b00, '0);
        check(tag, csr_rdata, exp);
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rst = 1'b0; idle();
        #12;
        // reset state
        rd("rst_mstatus", 12'h300, 32'h1800);
        rd("rst_mtvec",   12'h305, 32'h0);
        check("rst_mie", {31'b0, mie_o}, 32'h0);
        check("rst_redir_v", {31'b0, redirect_valid}, 32'h0);
        check("rst_redir_pc", redirect_pc, 32'h0);
        rst = 1'b1;
        step();

        // RW mtvec: pre-write read, forced low bits
        drive(12'h305, 2'b01, 32'h80000103);
        check("mtvec_prewrite", csr_rdata, 32'h0);
        step();
        rd("mtvec_rw", 12'h305, 32'h80000100);
        drive(12'h300, 2'b10, 32'h8); step();
        check("rs_mie", {31'b0, mie_o}, 32'h1);
        rd("rs_mstatus", 12'h300, 32'h1808);
        drive(12'h300, 2'b11, 32'h0); step();
        rd("rc0_mstatus", 12'h300, 32'h1808);
        // mscratch RW/RC/RS
        drive(12'h340, 2'b01, 32'hF0F0); step();
        drive(12'h340, 2'b11, 32'h30);   step();
        rd("rc_mscratch", 12'h340, 32'hF0C0);
        drive(12'h340, 2'b10, 32'h0F);   step();
        rd("rs_mscratch", 12'h340, 32'hF0CF);
        drive(12'h341, 2'b01, 32'h13);   step();
        rd("mepc_align", 12'h341, 32'h10);
        // mstatus writable mask
        drive(12'h300, 2'b01, 32'hFFFFFFFF); step();
        rd("mstatus_mask", 12'h300, 32'h1888);
        drive(12'h300, 2'b01, 32'h8); step();
        rd("mstatus_mie_only", 12'h300, 32'h1808);
        // unimplemented address
        drive(12'h123, 2'b01, 32'h1);
        check("illegal_flag", {31'b0, csr_illegal}, 32'h1);
        check("illegal_rdata", csr_rdata, 32'h0);
        drive(12'h123, 2'b00, 32'h0);
        check("illegal_none", {31'b0, csr_illegal}, 32'h0);
        check("idle_redir_pc", redirect_pc, 32'h0);

        // trap with MIE=1
        trap_valid = 1'b1; trap_cause = 32'd11; trap_pc = 32'h80000046; #1;
        check("trap_redir_v", {31'b0, redirect_valid}, 32'h1);
        check("trap_redir_pc", redirect_pc, 32'h80000100);
        step();
        rd("trap_mepc", 12'h341, 32'h80000044);
        rd("trap_mcause", 12'h342, 32'd11);
        rd("trap_mstatus", 12'h300, 32'h1880);
        check("trap_mie", {31'b0, mie_o}, 32'h0);

        // mret together with an mscratch write
        mret_valid = 1'b1; drive(12'h340, 2'b01, 32'h1234);
        check("mret_redir_pc", redirect_pc, 32'h80000044);
        check("mret_redir_v", {31'b0, redirect_valid}, 32'h1);
        step();
        rd("mret_mstatus", 12'h300, 32'h1888);
        rd("mret_mscratch", 12'h340, 32'h1234);

        // trap + mret + RW mscratch: trap wins, write dropped
        trap_valid = 1'b1; mret_valid = 1'b1; trap_cause = 32'd5; trap_pc = 32'h80000010;
        drive(12'h340, 2'b01, 32'h55);
        check("both_redir_pc", redirect_pc, 32'h80000100);
        step();
        rd("both_mscratch", 12'h340, 32'h1234);
        rd("both_mepc", 12'h341, 32'h80000010);
        rd("both_mcause", 12'h342, 32'd5);
        rd("both_mstatus", 12'h300, 32'h1880);

        // mret beats an mstatus write in the same cycle
        mret_valid = 1'b1; drive(12'h300, 2'b01, 32'h0); step();
        rd("mret_vs_wr", 12'h300, 32'h1888);

`ifdef YSYX_25030093_CSR_COUNTERS_EN
        drive(12'hB00, 2'b01, 32'hFFFFFFFF); step();
        drive(12'hB80, 2'b01, 32'hFFFFFFFF); step();
        rd("mcycle_hold", 12'hB00, 32'hFFFFFFFF);
        rd("mcycleh_set", 12'hB80, 32'hFFFFFFFF);
        step();
        rd("mcycle_wrap", 12'hB00, 32'h0);
        rd("mcycleh_wrap", 12'hB80, 32'h0);
        retire = 1'b1; drive(12'hB02, 2'b01, 32'h5); step();
        rd("minstret_wr", 12'hB02, 32'h5);
        retire = 1'b1; step();
        rd("minstret_inc", 12'hB02, 32'h6);
        step();
        rd("minstret_hold", 12'hB02, 32'h6);
        rd("minstreth", 12'hB82, 32'h0);
`else
        drive(12'hB00, 2'b01, 32'h1);
        check("nocnt_illegal", {31'b0, csr_illegal}, 32'h1);
        check("nocnt_rdata", csr_rdata, 32'h0);
`endif

        // asynchronous reset mid-cycle discards pending trap state
        @(negedge clk);
        trap_valid = 1'b1; trap_cause = 32'd2; trap_pc = 32'h40; #1;
        rst = 1'b0; idle(); #1;
        rd("arst_mstatus", 12'h300, 32'h1800);
        rd("arst_mscratch", 12'h340, 32'h0);
        rd("arst_mepc", 12'h341, 32'h0);
        check("arst_mie", {31'b0, mie_o}, 32'h0);
        check("arst_redir_v", {31'b0, redirect_valid}, 32'h0);
        rst = 1'b1;
        step();
        rd("post_mtvec", 12'h305, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
